// File: rtl/lift_controller.sv
// Two-floor lift controller: sequences the car between ground and top
// landings, with emergency and maintenance overrides. Outputs are a Moore
// decode of the state register.
module lift_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_button,
  input  logic       down_button,
  input  logic       doors_closed,
  input  logic       top_floor,
  input  logic       ground_floor,
  input  logic       emergency,
  input  logic       maintenance,
  output logic [3:0] state,
  output logic       motor_on,
  output logic       motor_direction,
  output logic       fan_on
);

  typedef enum logic [3:0] {
    GROUND        = 4'd0,
    STARTING_UP   = 4'd1,
    GOING_UP      = 4'd2,
    TOP           = 4'd3,
    STARTING_DOWN = 4'd4,
    GOING_DOWN    = 4'd5,
    EMERGENCY     = 4'd6,
    MAINTENANCE   = 4'd7
  } state_t;

  state_t cur_state;
  state_t next_state;
  logic   next_motor_on;
  logic   next_motor_direction;
  logic   next_fan_on;

  // Next-state selection: emergency beats maintenance beats normal travel.
  always_comb begin
    next_state = cur_state;
    if (emergency) begin
      next_state = EMERGENCY;
    end else if (maintenance) begin
      next_state = MAINTENANCE;
    end else begin
      unique case (cur_state)
        GROUND:        if (up_button && !top_floor)      next_state = STARTING_UP;
        STARTING_UP:   if (doors_closed)                 next_state = GOING_UP;
        GOING_UP:      if (top_floor)                    next_state = TOP;
        TOP:           if (down_button && !ground_floor) next_state = STARTING_DOWN;
        STARTING_DOWN: if (doors_closed)                 next_state = GOING_DOWN;
        GOING_DOWN:    if (ground_floor)                 next_state = GROUND;
        EMERGENCY, MAINTENANCE: begin
          // Override released: park where the car is, otherwise head down.
          if (ground_floor)   next_state = GROUND;
          else if (top_floor) next_state = TOP;
          else                next_state = STARTING_DOWN;
        end
        default:                                         next_state = GROUND;
      endcase
    end
  end

  // Output decode of the state about to be loaded, so the registered
  // outputs line up with the state register in the same cycle.
  always_comb begin
    next_motor_on        = 1'b0;
    next_motor_direction = 1'b0;
    next_fan_on          = 1'b0;
    unique case (next_state)
      STARTING_UP: begin
        next_motor_direction = 1'b1;
        next_fan_on          = 1'b1;
      end
      GOING_UP: begin
        next_motor_on        = 1'b1;
        next_motor_direction = 1'b1;
        next_fan_on          = 1'b1;
      end
      STARTING_DOWN: next_fan_on = 1'b1;
      GOING_DOWN: begin
        next_motor_on = 1'b1;
        next_fan_on   = 1'b1;
      end
      EMERGENCY:     next_fan_on = 1'b1;
      default: begin
        next_motor_on        = 1'b0;
        next_motor_direction = 1'b0;
        next_fan_on          = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks the car at GROUND, motor off.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state       <= GROUND;
      motor_on        <= 1'b0;
      motor_direction <= 1'b0;
      fan_on          <= 1'b0;
    end else begin
      cur_state       <= next_state;
      motor_on        <= next_motor_on;
      motor_direction <= next_motor_direction;
      fan_on          <= next_fan_on;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_lift_controller.sv
// Bench for lift_controller: directed trips and overrides, then random
// input sequences, all checked against a rule-level reference model.
module tb_lift_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       up_button = 1'b0;
  logic       down_button = 1'b0;
  logic       doors_closed = 1'b0;
  logic       top_floor = 1'b0;
  logic       ground_floor = 1'b0;
  logic       emergency = 1'b0;
  logic       maintenance = 1'b0;
  logic [3:0] state;
  logic       motor_on;
  logic       motor_direction;
  logic       fan_on;

  int n_checks = 0;
  int n_fail   = 0;
  int m_state  = 0;

  lift_controller dut (
    .clk             (clk),
    .reset           (reset),
    .up_button       (up_button),
    .down_button     (down_button),
    .doors_closed    (doors_closed),
    .top_floor       (top_floor),
    .ground_floor    (ground_floor),
    .emergency       (emergency),
    .maintenance     (maintenance),
    .state           (state),
    .motor_on        (motor_on),
    .motor_direction (motor_direction),
    .fan_on          (fan_on)
  );

  always #5 clk = ~clk;

  // Rule-level model: 0 GROUND,1 ST_UP,2 UP,3 TOP,4 ST_DN,5 DN,6 EMERG,7 MAINT
  function automatic int model_next(int s, bit u, bit d, bit dc, bit t,
                                    bit g, bit e, bit m, bit r);
    if (r) return 0;
    if (e) return 6;
    if (m) return 7;
    if (s == 6 || s == 7) return g ? 0 : (t ? 3 : 4);
    case (s)
      0: return (u && !t) ? 1 : 0;
      1: return dc ? 2 : 1;
      2: return t ? 3 : 2;
      3: return (d && !g) ? 4 : 3;
      4: return dc ? 5 : 4;
      5: return g ? 0 : 5;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Apply one set of inputs across a rising edge, then compare on the
  // falling edge. exp_state >= 0 adds a hand-derived state expectation.
  task automatic step(input bit u, input bit d, input bit dc, input bit t,
                      input bit g, input bit e, input bit m, input bit r,
                      input int exp_state);
    up_button = u; down_button = d; doors_closed = dc; top_floor = t;
    ground_floor = g; emergency = e; maintenance = m; reset = r;
    @(posedge clk);
    m_state = model_next(m_state, u, d, dc, t, g, e, m, r);
    @(negedge clk);
    if (exp_state >= 0) check("directed_state", int'(state), exp_state);
    check("state", int'(state), m_state);
    check("motor_on", int'(motor_on), (m_state == 2 || m_state == 5) ? 1 : 0);
    check("motor_direction", int'(motor_direction),
          (m_state == 1 || m_state == 2) ? 1 : 0);
    check("fan_on", int'(fan_on),
          (m_state >= 1 && m_state <= 6) && m_state != 3 ? 1 : 0);
  endtask

  initial begin
    @(negedge clk);
    //   u  d dc  t  g  e  m  r  exp
    step(0, 0, 0, 0, 1, 0, 0, 1, 0);   // reset
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);   // idle at ground holds
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0, 0);   // down call ignored at ground
    // Up trip
    step(1, 0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0, 0, 0, 1);   // doors still open
    step(0, 0, 1, 0, 0, 0, 0, 0, 2);
    step(0, 0, 1, 0, 0, 0, 0, 0, 2);
    step(0, 0, 1, 1, 0, 0, 0, 0, 3);
    step(1, 0, 1, 1, 0, 0, 0, 0, 3);   // up call ignored at top
    // Down trip
    step(0, 1, 0, 1, 0, 0, 0, 0, 4);
    step(0, 0, 1, 0, 0, 0, 0, 0, 5);
    step(0, 0, 1, 0, 1, 0, 0, 0, 0);
    // Emergency while going up, recovery between floors then at ground
    step(1, 0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 2);
    step(0, 0, 1, 0, 0, 1, 0, 0, 6);
    step(0, 0, 1, 0, 0, 1, 0, 0, 6);
    step(0, 0, 0, 0, 0, 0, 0, 0, 4);
    step(0, 0, 0, 0, 0, 1, 0, 0, 6);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Emergency + maintenance together, then hand-off and release at top
    step(0, 0, 0, 0, 1, 1, 1, 0, 6);
    step(0, 0, 0, 0, 1, 0, 1, 0, 7);
    step(0, 0, 0, 0, 1, 0, 1, 0, 7);
    step(0, 0, 0, 1, 0, 0, 0, 0, 3);
    // Reset with emergency while going down; blocked departure at ground
    step(0, 1, 0, 1, 0, 0, 0, 0, 4);
    step(0, 0, 1, 0, 0, 0, 0, 0, 5);
    step(0, 0, 1, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    // Sensor conflict: GOING_UP still lands at TOP
    step(1, 0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, 2);
    step(0, 0, 1, 1, 1, 0, 0, 0, 3);
    step(0, 1, 0, 1, 1, 0, 0, 0, 3);

    // Random phase: overrides and reset kept rare so trips complete.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 49) == 0),
           -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
